modulo_entrada: RTL and testbench
=================================

// Module: modulo_entrada
// PURPOSE
//  Input conditioning stage upstream of the processor's Entrada instruction path.
//  Synchronises and debounces the raw board push-button and switch bank on the board clock.
//  On each accepted press, captures one 16-bit switch word and presents it with a valid/ack handshake.
//  Replaces the processor's ad-hoc two-flag edge detection on ent with a clean, single-word source.
// PARAMETERS
//  DATA_W          16      switch word width
//  DEBOUNCE_CYCLES 500000  stable clk0 cycles required to accept a level change (10 ms @ 50 MHz); must be >= 2
//  CNT_W           20      debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk0     in   1       board clock; all state updates on posedge
//  reset    in   1       asynchronous, active-low; clears all state
//  ent_n    in   1       raw push-button, active-low, asynchronous, bouncing
//  switch   in   DATA_W  raw switch bank, asynchronous
//  ack      in   1       consumer has taken dado; sampled on posedge clk0 (synchronous to clk0)
//  valid    out  1       dado holds an unconsumed word
//  dado     out  DATA_W  captured switch word
//  pressed  out  1       debounced button level (1 = held)
//  overrun  out  1       sticky: a press was accepted while valid=1
// BEHAVIOUR
//  Reset (reset=0, async): valid=0, dado=0, pressed=0, overrun=0, state=SOLTO, cnt=0.
//   Synchroniser flops go to the released level (ent 1, switch 0).
//  Sync: 2-flop synchroniser on ent_n and on every switch bit; the FSM sees only synchronised values.
//  FSM (the counter cnt is cleared on every state change):
//   SOLTO:        sync_ent=0 -> FILTRA_PRESS.
//   FILTRA_PRESS: sync_ent=1 -> SOLTO (bounce rejected).
//                 sync_ent=0, cnt==DEBOUNCE_CYCLES-1 -> PRESSIONADO; accept press. Otherwise cnt++.
//   PRESSIONADO:  pressed=1; sync_ent=1 -> FILTRA_SOLTA.
//   FILTRA_SOLTA: sync_ent=0 -> PRESSIONADO.
//                 sync_ent=1, cnt==DEBOUNCE_CYCLES-1 -> SOLTO. Otherwise cnt++.
//  pressed=1 in PRESSIONADO and FILTRA_SOLTA, 0 otherwise (registered with the state).
//  Accept press: if valid=0 or ack=1 on that edge -> dado<=sync_switch, valid<=1.
//   Else (valid=1, ack=0) -> dado unchanged, valid stays 1, overrun<=1.
//  Handshake: valid=1 and ack=1 on an edge with no press accepted -> valid<=0 on that edge.
//   ack while valid=0 is ignored. dado is stable while valid=1.
//  Latency: ent_n held low from edge N -> valid=1 after edge N+DEBOUNCE_CYCLES+2.
//   Breakdown: 2 sync + 1 state entry + DEBOUNCE_CYCLES-1 counts.
//  Switch word is sampled from the synchroniser on the accepting edge only; switch changes at other times are ignored.
//  One press yields exactly one word regardless of hold time; a new word needs release (debounced) and re-press.
//  overrun clears only on reset.
//  Async reset mid-filter or with valid=1 discards the pending word; the button, if still held, must be re-debounced from SOLTO.
//  cnt never wraps: bounded by DEBOUNCE_CYCLES-1.
// STRUCTURE
//  Shared header (entrada_defs.vh): FSM state encodings SOLTO=2'd0, FILTRA_PRESS=2'd1, PRESSIONADO=2'd2,
//   FILTRA_SOLTA=2'd3; DATA_W default.
//  Sub-module sincronizador #(W): W-bit 2-flop synchroniser with async active-low reset and per-instance reset value.
//   Instantiated twice: ent_n (reset value 1) and switch (reset value 0).
//  FSM, counter and capture/handshake register live in modulo_entrada.
// TESTING  (DEBOUNCE_CYCLES=4)
//  1 Reset: hold reset=0 with ent_n=0, switch=16'hFFFF -> all outputs 0; release reset, ent_n=1 -> outputs stay 0.
//  2 Clean press: switch=16'hA5C3, ent_n 1->0 at edge N -> valid=1, dado=16'hA5C3 after edge N+6, not earlier;
//     pressed=1 from the same edge.
//  3 Bounce: ent_n low 2 cycles, high 1, low 2, high -> valid, pressed never assert; then a stable low press is accepted normally.
//  4 Handshake: after test 2, ack=1 one cycle -> valid=0 next edge; holding ent_n low 1000 cycles yields no second word.
//  5 Overrun: two debounced presses (switch 16'h0001 then 16'h0002), no ack -> dado=16'h0001, overrun=1 sticky.
//     Then ack -> valid=0, overrun stays 1.
//  6 Simultaneous: ack=1 on the accepting edge of the second press (16'h0002) -> valid stays 1, dado=16'h0002, overrun=0.
//     Async reset mid-FILTRA_PRESS -> state SOLTO, no word produced.

Source files
------------

// File: rtl/modulo_entrada_pkg.sv
// Shared types for the Entrada input conditioning stage: button FSM states and defaults.
package modulo_entrada_pkg;

  typedef enum logic [1:0] {
    SOLTO        = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;

  localparam int DATA_W_DEF = 16;

  function automatic logic is_held(input estado_t st);
    return (st == PRESSIONADO) || (st == FILTRA_SOLTA);
  endfunction

endpackage

// File: rtl/modulo_entrada_sincronizador.sv
// W-bit two-flop synchroniser; both stages reset to RST_VAL so the idle level is seen from reset.
module sincronizador #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk0,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/modulo_entrada.sv
// Debounces the Entrada push-button and captures one switch word per accepted press behind a valid/ack handshake.
module modulo_entrada
  import modulo_entrada_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              ent_n,
  input  logic [DATA_W-1:0] switch,
  input  logic              ack,
  output logic              valid,
  output logic [DATA_W-1:0] dado,
  output logic              pressed,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              ent_s;
  logic [DATA_W-1:0] sw_s;

  sincronizador #(.W(1), .RST_VAL(1'b1)) u_sync_ent (
    .clk0  (clk0),
    .reset (reset),
    .d_i   (ent_n),
    .q_o   (ent_s)
  );

  sincronizador #(.W(DATA_W), .RST_VAL('0)) u_sync_sw (
    .clk0  (clk0),
    .reset (reset),
    .d_i   (switch),
    .q_o   (sw_s)
  );

  estado_t           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pressed_q, pressed_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic              accept;

  // Debounce FSM: the counter restarts on every state change, so it never exceeds CNT_MAX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      SOLTO: begin
        cnt_d = '0;
        if (!ent_s) state_d = FILTRA_PRESS;
      end
      FILTRA_PRESS: begin
        if (ent_s) begin
          state_d = SOLTO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSIONADO;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSIONADO: begin
        cnt_d = '0;
        if (ent_s) state_d = FILTRA_SOLTA;
      end
      FILTRA_SOLTA: begin
        if (!ent_s) begin
          state_d = PRESSIONADO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = SOLTO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = SOLTO;
        cnt_d   = '0;
      end
    endcase
    pressed_d = is_held(state_d);
  end

  // An accepted press while a word is still pending keeps the old word and flags overrun,
  // unless the consumer acks on that very edge.
  always_comb begin
    valid_d   = valid_q;
    dado_d    = dado_q;
    overrun_d = overrun_q;
    if (accept) begin
      if (!valid_q || ack) begin
        dado_d  = sw_s;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state_q   <= SOLTO;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      dado_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      dado_q    <= dado_d;
    end
  end

  assign valid   = valid_q;
  assign dado    = dado_q;
  assign pressed = pressed_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_modulo_entrada.sv
// Scoreboard bench for modulo_entrada with a short debounce window.
module tb_modulo_entrada;

  localparam int DW = 16;
  localparam int DB = 4;

  logic          clk0 = 1'b0;
  logic          reset;
  logic          ent_n;
  logic [DW-1:0] switch;
  logic          ack;
  logic          valid;
  logic [DW-1:0] dado;
  logic          pressed;
  logic          overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q[$];

  modulo_entrada #(
    .DATA_W          (DW),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (20)
  ) dut (
    .clk0    (clk0),
    .reset   (reset),
    .ent_n   (ent_n),
    .switch  (switch),
    .ack     (ack),
    .valid   (valid),
    .dado    (dado),
    .pressed (pressed),
    .overrun (overrun)
  );

  always #5 clk0 = ~clk0;

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clk0);
    ent_n = 1'b1;
    repeat (DB + 6) step();
  endtask

  task automatic wait_word(input string name);
    logic [DW-1:0] e;
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (valid) begin
        seen = 1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s: valid never asserted within 50 cycles", name);
    end else if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: word %h produced, none expected", name, dado);
    end else begin
      e = exp_q.pop_front();
      if (dado !== e) begin
        tests_failed++;
        $display("FAIL %s: dado=%h expected %h", name, dado, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ent_n = 1'b0; switch = 16'hFFFF; ack = 1'b0;
    repeat (5) step();
    tests_run++;
    if ({valid, dado, pressed, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: v=%b d=%h p=%b o=%b expected all 0", valid, dado, pressed, overrun);
    end
    @(negedge clk0);
    reset = 1'b1; ent_n = 1'b1;
    repeat (10) step();
    tests_run++;
    if ({valid, dado, pressed, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL reset_release: v=%b d=%h p=%b o=%b expected all 0", valid, dado, pressed, overrun);
    end
  endtask

  task automatic test_clean_press();
    logic [DW-1:0] e;
    switch = 16'hA5C3;
    repeat (3) step();
    @(negedge clk0);
    ent_n = 1'b0;
    exp_q.push_back(16'hA5C3);
    for (int i = 0; i <= 6; i++) begin
      step();
      if (i < 6) begin
        tests_run++;
        if (valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL press_early edge+%0d: valid=%b expected 0", i, valid);
        end
      end
      if (i == 5) begin
        tests_run++;
        if (pressed !== 1'b0) begin
          tests_failed++;
          $display("FAIL pressed_early: pressed=%b expected 0", pressed);
        end
      end
    end
    tests_run++;
    if (valid !== 1'b1 || pressed !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_latency: valid=%b pressed=%b expected 1 1", valid, pressed);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (dado !== e) begin
      tests_failed++;
      $display("FAIL press_data: dado=%h expected %h", dado, e);
    end
  endtask

  task automatic test_handshake();
    bit extra;
    @(negedge clk0);
    ack = 1'b1;
    step();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_clear: valid=%b expected 0", valid);
    end
    @(negedge clk0);
    ack = 1'b0;
    extra = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (valid !== 1'b0) extra = 1;
    end
    tests_run++;
    if (extra) begin
      tests_failed++;
      $display("FAIL hold_single_word: valid=1 seen expected 0");
    end
    release_btn();
    tests_run++;
    if (pressed !== 1'b0) begin
      tests_failed++;
      $display("FAIL release: pressed=%b expected 0", pressed);
    end
  endtask

  task automatic test_bounce();
    bit bad;
    bit pat [7] = '{0, 0, 1, 0, 0, 1, 1};
    bad = 0;
    switch = 16'h3C3C;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk0);
      ent_n = pat[i];
      step();
      if (valid !== 1'b0 || pressed !== 1'b0) bad = 1;
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid !== 1'b0 || pressed !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL bounce: valid/pressed asserted, expected 0");
    end
    @(negedge clk0);
    ent_n = 1'b0;
    exp_q.push_back(16'h3C3C);
    wait_word("bounce_then_press");
    @(negedge clk0);
    ack = 1'b1;
    @(negedge clk0);
    ack = 1'b0;
    release_btn();
  endtask

  task automatic test_overrun();
    switch = 16'h0001;
    @(negedge clk0);
    ent_n = 1'b0;
    exp_q.push_back(16'h0001);
    wait_word("overrun_first");
    release_btn();
    switch = 16'h0002;
    @(negedge clk0);
    ent_n = 1'b0;
    repeat (DB + 6) step();
    tests_run++;
    if (valid !== 1'b1 || dado !== 16'h0001 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun: v=%b d=%h o=%b expected 1 0001 1", valid, dado, overrun);
    end
    release_btn();
    @(negedge clk0);
    ack = 1'b1;
    step();
    tests_run++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_sticky: v=%b o=%b expected 0 1", valid, overrun);
    end
    @(negedge clk0);
    ack = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] e;
    bit bad;
    @(negedge clk0);
    reset = 1'b0;
    @(negedge clk0);
    reset = 1'b1;
    switch = 16'h0001;
    @(negedge clk0);
    ent_n = 1'b0;
    exp_q.push_back(16'h0001);
    wait_word("simul_first");
    release_btn();
    switch = 16'h0002;
    repeat (3) step();
    @(negedge clk0);
    ent_n = 1'b0;
    exp_q.push_back(16'h0002);
    for (int i = 0; i < 6; i++) step();
    @(negedge clk0);
    ack = 1'b1;
    step();
    @(negedge clk0);
    ack = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (valid !== 1'b1 || dado !== e || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_ack: v=%b d=%h o=%b expected 1 %h 0", valid, dado, overrun, e);
    end
    release_btn();
    @(negedge clk0);
    ack = 1'b1;
    @(negedge clk0);
    ack = 1'b0;
    switch = 16'h7777;
    ent_n = 1'b0;
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({valid, pressed, overrun, dado} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: v=%b p=%b o=%b d=%h expected all 0", valid, pressed, overrun, dado);
    end
    @(negedge clk0);
    reset = 1'b1;
    ent_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid !== 1'b0 || pressed !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL reset_discard: word or press seen after mid-filter reset");
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_handshake();
    test_bounce();
    test_overrun();
    test_simultaneous();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_left: %0d words never produced", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
